// File: rtl/cache_mon_pkg.sv
// cache_mon_pkg
// Shared types and constants for the cache performance monitor.
//   evt_e       : readout event codes (READS..ACCESSES; codes 6-7 are unused)
//   ch_state_e  : per-channel access-tracking FSM state
//   N_CNT       : number of physically stored counters per channel
//   N_EVT       : number of defined readout events (ACCESSES is derived)
package cache_mon_pkg;

    typedef enum logic [2:0] {
        EVT_READS    = 3'd0,
        EVT_WRITES   = 3'd1,
        EVT_HITS     = 3'd2,
        EVT_MISSES   = 3'd3,
        EVT_STALLS   = 3'd4,
        EVT_ACCESSES = 3'd5
    } evt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ch_state_e;

    // READS, WRITES, HITS, MISSES, STALLS are stored; ACCESSES is computed at readout
    localparam int N_CNT = 5;
    localparam int N_EVT = 6;

endpackage

// File: rtl/cache_mon_channel.sv
// cache_mon_channel
// One monitored cache port: access FSM, saturating event counters,
// sticky saturation flag and consecutive-miss run counter.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_rd, i_wr        : access request (both high = write)
//   i_hit             : hit flag, valid with i_ready
//   i_ready           : access complete
//   i_clear           : zero counters, sat and miss run (FSM untouched)
//   i_freeze          : hold counters and sat
//   o_cnt             : stored counters, indexed by evt_e (READS..STALLS)
//   o_sat             : some counter reached its maximum (sticky)
//   o_miss_alarm      : miss run has reached MISS_THR
module cache_mon_channel
    import cache_mon_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MISS_THR = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rd,
    input  logic                          i_wr,
    input  logic                          i_hit,
    input  logic                          i_ready,
    input  logic                          i_clear,
    input  logic                          i_freeze,
    output logic [N_CNT-1:0][CNT_W-1:0]   o_cnt,
    output logic                          o_sat,
    output logic                          o_miss_alarm
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;
    localparam int               RUN_W      = $clog2(MISS_THR + 1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MISS_THR);

    ch_state_e        r_state;
    ch_state_e        w_state_next;
    logic             r_type_wr;
    logic             w_type_wr_next;
    logic             w_done;
    logic             w_done_wr;
    logic             w_stall;
    logic [N_CNT-1:0] w_inc;
    logic [N_CNT-1:0] w_to_max;
    logic             r_sat;
    logic [RUN_W-1:0] r_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_type_wr <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_type_wr <= w_type_wr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_type_wr_next = r_type_wr;
        w_done         = 1'b0;
        w_done_wr      = 1'b0;
        w_stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rd || i_wr) begin
                    if (i_ready) begin
                        w_done    = 1'b1;
                        w_done_wr = i_wr;
                    end else begin
                        w_state_next   = ST_BUSY;
                        w_type_wr_next = i_wr;
                    end
                end
            end
            ST_BUSY: begin
                // new requests are ignored until the outstanding one finishes
                if (i_ready) begin
                    w_done       = 1'b1;
                    w_done_wr    = r_type_wr;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_inc[EVT_READS]  = w_done && !w_done_wr;
    assign w_inc[EVT_WRITES] = w_done &&  w_done_wr;
    assign w_inc[EVT_HITS]   = w_done &&  i_hit;
    assign w_inc[EVT_MISSES] = w_done && !i_hit;
    assign w_inc[EVT_STALLS] = w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // flags the increment that lands exactly on the maximum value
            assign w_to_max[gi] = w_inc[gi] && (r_cnt == CNT_MAX_M1);
            assign o_cnt[gi]    = r_cnt;

            always_ff @(posedge clk) begin
                if (reset || i_clear) begin
                    r_cnt <= '0;
                end else if (!i_freeze && w_inc[gi] && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_sat <= 1'b0;
        end else if (!i_freeze && (|w_to_max)) begin
            r_sat <= 1'b1;
        end
    end

    // miss run keeps tracking while frozen; only clear/reset zero it
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_run <= '0;
        end else if (w_done) begin
            if (i_hit) begin
                r_run <= '0;
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + 1'b1;
            end
        end
    end

    assign o_sat        = r_sat;
    assign o_miss_alarm = (r_run == RUN_MAX);

endmodule

// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor
// Multi-port cache performance monitor: one cache_mon_channel per port plus
// a registered counter readout.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   rd, wr, hit,
//   ready            : per-channel access handshake
//   clear, freeze    : global counter clear / hold (clear wins)
//   sel_ch, sel_evt  : readout channel and event code
//   rdata            : selected counter, one cycle after selection
//   sat              : per-channel sticky saturation flag
//   miss_alarm       : per-channel consecutive-miss alarm
module cache_perf_monitor
    import cache_mon_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int MISS_THR = 16,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] rd,
    input  logic [NUM_CH-1:0] wr,
    input  logic [NUM_CH-1:0] hit,
    input  logic [NUM_CH-1:0] ready,
    input  logic              clear,
    input  logic              freeze,
    input  logic [SEL_W-1:0]  sel_ch,
    input  logic [2:0]        sel_evt,
    output logic [CNT_W-1:0]  rdata,
    output logic [NUM_CH-1:0] sat,
    output logic [NUM_CH-1:0] miss_alarm
);

    logic [N_CNT-1:0][CNT_W-1:0] w_cnt [NUM_CH];
    logic [N_CNT-1:0][CNT_W-1:0] w_sel_cnt;
    logic [CNT_W:0]              w_sum;
    logic [CNT_W-1:0]            w_rd_val;
    logic [CNT_W-1:0]            r_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            cache_mon_channel #(
                .CNT_W    (CNT_W),
                .MISS_THR (MISS_THR)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .i_rd         (rd[gi]),
                .i_wr         (wr[gi]),
                .i_hit        (hit[gi]),
                .i_ready      (ready[gi]),
                .i_clear      (clear),
                .i_freeze     (freeze),
                .o_cnt        (w_cnt[gi]),
                .o_sat        (sat[gi]),
                .o_miss_alarm (miss_alarm[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rd_val  = '0;
        w_sel_cnt = '0;
        w_sum     = '0;
        // non-power-of-two channel counts leave unused select codes reading 0
        if ({1'b0, sel_ch} < (SEL_W + 1)'(NUM_CH)) begin
            w_sel_cnt = w_cnt[sel_ch];
            w_sum     = {1'b0, w_sel_cnt[EVT_READS]} + {1'b0, w_sel_cnt[EVT_WRITES]};
            case (sel_evt)
                EVT_READS:    w_rd_val = w_sel_cnt[EVT_READS];
                EVT_WRITES:   w_rd_val = w_sel_cnt[EVT_WRITES];
                EVT_HITS:     w_rd_val = w_sel_cnt[EVT_HITS];
                EVT_MISSES:   w_rd_val = w_sel_cnt[EVT_MISSES];
                EVT_STALLS:   w_rd_val = w_sel_cnt[EVT_STALLS];
                EVT_ACCESSES: w_rd_val = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
                default:      w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_val;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_cache_perf_monitor.sv
module tb_cache_perf_monitor;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int MISS_THR = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] rd, wr, hit, ready;
    logic              clear, freeze;
    logic [0:0]        sel_ch;
    logic [2:0]        sel_evt;
    logic [CNT_W-1:0]  rdata;
    logic [NUM_CH-1:0] sat, miss_alarm;

    always #5 clk = ~clk;

    cache_perf_monitor #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .MISS_THR (MISS_THR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .hit        (hit),
        .ready      (ready),
        .clear      (clear),
        .freeze     (freeze),
        .sel_ch     (sel_ch),
        .sel_evt    (sel_evt),
        .rdata      (rdata),
        .sat        (sat),
        .miss_alarm (miss_alarm)
    );

    // sig: 0 = rdata, 1 = sat vector, 2 = miss_alarm vector
    typedef struct {
        int          sig;
        logic [47:0] exp;
        string       nm;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        req    = 1'b0;
    logic        req_d  = 1'b0;
    item_t       m_it;
    logic [47:0] m_act;

    // a readout request presented before an edge has its answer after that edge
    always @(posedge clk) req_d <= req;

    always @(negedge clk) begin
        if (req_d) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow actual=output_present required=expected_entry");
            end else begin
                m_it = sb.pop_front();
                case (m_it.sig)
                    0:       m_act = 48'(rdata);
                    1:       m_act = 48'(sat);
                    default: m_act = 48'(miss_alarm);
                endcase
                checks++;
                if (m_act !== m_it.exp) begin
                    errors++;
                    $display("FAIL %s actual=%0d required=%0d", m_it.nm, m_act, m_it.exp);
                end else begin
                    $display("ok   %s value=%0d", m_it.nm, m_act);
                end
            end
        end
    end

    task automatic push_chk(input int sig, input int ch, input int evt,
                            input int exp, input string nm);
        item_t it;
        @(negedge clk);
        sel_ch  = 1'(ch);
        sel_evt = 3'(evt);
        it.sig  = sig;
        it.exp  = 48'(exp);
        it.nm   = nm;
        sb.push_back(it);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic chk_rd(input int ch, input int evt, input int exp, input string nm);
        push_chk(0, ch, evt, exp, nm);
    endtask

    task automatic chk_sat(input int exp, input string nm);
        push_chk(1, 0, 0, exp, nm);
    endtask

    task automatic chk_alarm(input int exp, input string nm);
        push_chk(2, 0, 0, exp, nm);
    endtask

    task automatic drive_idle();
        rd    = '0;
        wr    = '0;
        ready = '0;
        hit   = '0;
    endtask

    // single-cycle completed access on channel ch
    task automatic acc(input int ch, input bit w, input bit h);
        @(negedge clk);
        rd[ch]    = ~w;
        wr[ch]    = w;
        ready[ch] = 1'b1;
        hit[ch]   = h;
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        reset   = 1'b1;
        clear   = 1'b0;
        freeze  = 1'b0;
        sel_ch  = '0;
        sel_evt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk_rd(0, 0, 0, "rst_rdata");
        chk_sat(0, "rst_sat");
        chk_alarm(0, "rst_alarm");

        // ch1 write hit
        acc(1, 1'b1, 1'b1);
        chk_rd(1, 1, 1, "wr_writes");
        chk_rd(1, 2, 1, "wr_hits");
        chk_rd(1, 3, 0, "wr_misses");
        chk_rd(1, 0, 0, "wr_reads");
        chk_rd(1, 5, 1, "wr_accesses");
        chk_rd(0, 1, 0, "wr_ch0_untouched");

        // ch0 read: request cycle, three BUSY cycles with ready low (rd toggling), then miss
        @(negedge clk); rd[0] = 1'b1; ready[0] = 1'b0;
        @(negedge clk); rd[0] = 1'b0;
        @(negedge clk); rd[0] = 1'b1;
        @(negedge clk); rd[0] = 1'b0;
        @(negedge clk); ready[0] = 1'b1; hit[0] = 1'b0;
        @(negedge clk); drive_idle();
        chk_rd(0, 0, 1, "stall_reads");
        chk_rd(0, 1, 0, "stall_writes");
        chk_rd(0, 3, 1, "stall_misses");
        chk_rd(0, 4, 3, "stall_stalls");
        chk_rd(0, 6, 0, "code6_zero");
        chk_rd(0, 7, 0, "code7_zero");

        // consecutive misses on ch1
        repeat (15) acc(1, 1'b0, 1'b0);
        chk_alarm(0, "alarm_after_15");
        acc(1, 1'b0, 1'b0);
        chk_alarm(2, "alarm_after_16");
        acc(1, 1'b0, 1'b1);
        chk_alarm(0, "alarm_hit_drop");
        chk_rd(1, 0, 17, "miss_reads");
        chk_rd(1, 3, 16, "miss_misses");
        chk_rd(1, 5, 18, "miss_accesses");

        // freeze holds counters
        freeze = 1'b1;
        repeat (5) acc(1, 1'b0, 1'b1);
        freeze = 1'b0;
        chk_rd(1, 2, 2, "freeze_hits");
        chk_rd(1, 0, 17, "freeze_reads");
        acc(1, 1'b0, 1'b1);
        chk_rd(1, 2, 3, "unfreeze_hits");

        // saturation with CNT_W = 8
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk_rd(1, 0, 0, "clear_reads");
        @(negedge clk); rd[0] = 1'b1; ready[0] = 1'b1; hit[0] = 1'b1;
        repeat (300) @(negedge clk);
        drive_idle();
        chk_rd(0, 2, 255, "sat_hits");
        chk_rd(0, 0, 255, "sat_reads");
        chk_rd(0, 5, 255, "sat_accesses");
        chk_sat(1, "sat_flag");
        acc(0, 1'b1, 1'b1);
        chk_rd(0, 1, 1, "sat_writes");
        chk_rd(0, 5, 255, "sat_sum_clamp");

        // clear and freeze together with completions on both channels: clear wins
        @(negedge clk);
        clear = 1'b1; freeze = 1'b1;
        rd = 2'b11; ready = 2'b11; hit = 2'b00;
        @(negedge clk);
        clear = 1'b0; freeze = 1'b0;
        drive_idle();
        chk_rd(0, 0, 0, "clr_reads");
        chk_rd(0, 3, 0, "clr_misses");
        chk_rd(1, 3, 0, "clr_ch1_misses");
        chk_rd(1, 5, 0, "clr_ch1_accesses");
        chk_sat(0, "clr_sat");

        // reset while ch1 BUSY, then a stray ready
        @(negedge clk); rd[1] = 1'b1; ready[1] = 1'b0;
        @(negedge clk); rd[1] = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; ready[1] = 1'b1; hit[1] = 1'b1;
        @(negedge clk); drive_idle();
        chk_rd(1, 4, 0, "rstbusy_stalls");
        chk_rd(1, 0, 0, "rstbusy_reads");
        chk_rd(1, 2, 0, "rstbusy_hits");
        chk_rd(1, 5, 0, "rstbusy_accesses");
        acc(1, 1'b1, 1'b0);
        chk_rd(1, 1, 1, "post_rst_writes");
        chk_rd(1, 3, 1, "post_rst_misses");

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_perf_monitor.md
CACHE_PERF_MONITOR -- requirements
Module: cache_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of monitored cache ports (I-cache = ch0, D-cache = ch1).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of every event counter (legal range 8..48).
REQ-003 SHALL have parameter MISS_THR, default 16, meaning per-channel consecutive-miss alarm threshold.
REQ-004 SHALL use one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- rd  in  NUM_CH  per-channel read request.
- wr  in  NUM_CH  per-channel write request (ch0 tied 0 by integrator).
- hit  in  NUM_CH  per-channel hit flag, valid with ready.
- ready  in  NUM_CH  per-channel access-complete.
- clear  in  1  zero all counters.
- freeze  in  1  hold all counters.
- sel_ch  in  $clog2(NUM_CH) (min 1)  readout channel.
- sel_evt  in  3  readout event code.
- rdata  out  CNT_W  registered readout value.
- sat  out  NUM_CH  any counter of channel saturated (sticky).
- miss_alarm  out  NUM_CH  consecutive-miss count reached MISS_THR.

Function
REQ-006 Each channel SHALL run a 2-state FSM: IDLE, BUSY.
REQ-007 IDLE: rd|wr high with ready high SHALL complete the access that cycle; rd|wr high with ready low SHALL latch type (write if wr) and go BUSY.
REQ-008 BUSY: SHALL ignore rd/wr; ready high SHALL complete the access using the latched type and return to IDLE.
REQ-009 rd and wr both high in IDLE SHALL count as one write access.
REQ-010 On completion SHALL increment READS or WRITES per type, and HITS if hit else MISSES.
REQ-011 Each cycle in BUSY with ready low SHALL increment STALLS.
REQ-012 Event codes: 0 READS, 1 WRITES, 2 HITS, 3 MISSES, 4 STALLS, 5 ACCESSES (READS+WRITES, CNT_W-bit saturating sum computed at readout); codes 6-7 SHALL read 0.
REQ-013 Counters SHALL saturate at 2^CNT_W-1, never wrap; reaching saturation SHALL set sat[ch] until clear or reset.
REQ-014 Consecutive-miss counter per channel SHALL increment on miss completion, zero on hit completion, saturate at MISS_THR; miss_alarm[ch] SHALL be high while it equals MISS_THR.
REQ-015 rdata SHALL equal the selected counter as of the previous clock edge (1-cycle latency); a same-cycle increment is not visible until the following cycle.
REQ-016 freeze high SHALL hold all counters and sat; FSMs and miss-run counters SHALL keep tracking.
REQ-017 clear SHALL zero all counters, sat and miss-run counters next edge; clear coincident with an event SHALL win (result 0); clear SHALL NOT change FSM state.
REQ-018 clear and freeze both high SHALL clear.
REQ-019 Out-of-range sel_ch (NUM_CH not power of 2) SHALL read 0.

Reset
REQ-020 reset SHALL force all FSMs to IDLE, all counters and miss-run counters to 0, sat=0, miss_alarm=0, rdata=0; reset overrides clear/freeze.
REQ-021 Reset mid-access (BUSY) SHALL abandon the access uncounted; a ready arriving after reset with no new request SHALL be ignored.

Structure
REQ-022 Package cache_mon_pkg SHALL hold the event-code enum (EVT_READS..EVT_ACCESSES), the FSM state typedef and the event-count constant.
REQ-023 Per-channel FSM, counters and miss-run logic SHALL be sub-module cache_mon_channel, instantiated NUM_CH times by generate; top holds readout mux and rdata register.

Verification
REQ-024 ch1 wr=1 ready=1 hit=1 one cycle -> next cycle sel=(1,1) rdata=1, sel=(1,2) rdata=1, MISSES=0.
REQ-025 ch0 rd=1 ready=0 for 3 cycles then ready=1 hit=0 -> READS=1, MISSES=1, STALLS=3; rd toggling during BUSY adds nothing.
REQ-026 CNT_W=8, 300 hit completions on ch0 -> HITS=255, sat[0]=1; ACCESSES=255.
REQ-027 16 consecutive ch1 misses -> miss_alarm[1]=1 on cycle after 16th; one hit -> 0 next cycle.
REQ-028 freeze=1 during 5 hits -> HITS unchanged; clear with simultaneous completion -> all counters 0, sat=0.
REQ-029 reset asserted while ch1 BUSY, then ready=1 -> all counters 0, FSM IDLE, no count.
